// File: rtl/cprv_ex_stage.sv
// cprv64g execute stage: RV64I integer ALU and load/store address generation,
// registered into a single valid/ready pipeline slot toward MEM.
module cprv_ex_stage #(
   parameter int unsigned DATA_WIDTH = 64
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  valid_ex_i,
   output logic                  ready_ex_o,
   input  logic [DATA_WIDTH-1:0] rs1_data_ex_i,
   input  logic [DATA_WIDTH-1:0] rs2_data_ex_i,
   input  logic [4:0]            rd_addr_ex_i,
   input  logic                  rd_en_ex_i,
   input  logic [DATA_WIDTH-1:0] imm_data_ex_i,
   input  logic [6:0]            opcode_ex_i,
   input  logic [2:0]            funct3_ex_i,
   input  logic [6:0]            funct7_ex_i,
   input  logic                  mem_w_en_ex_i,
   output logic                  valid_mem_o,
   input  logic                  ready_mem_i,
   output logic [DATA_WIDTH-1:0] alu_result_mem_o,
   output logic [DATA_WIDTH-1:0] store_data_mem_o,
   output logic [4:0]            rd_addr_mem_o,
   output logic                  rd_en_mem_o,
   output logic                  mem_w_en_mem_o,
   output logic                  mem_r_en_mem_o,
   output logic [2:0]            funct3_mem_o
);

   typedef enum logic [6:0] {
      OPC_LOAD      = 7'b0000011,
      OPC_OP_IMM    = 7'b0010011,
      OPC_OP_IMM_32 = 7'b0011011,
      OPC_STORE     = 7'b0100011,
      OPC_OP        = 7'b0110011,
      OPC_OP_32     = 7'b0111011
   } opcode_e;

   opcode_e               opc;
   logic                  cke;
   logic                  reg_src;
   logic                  use_sub;
   logic [DATA_WIDTH-1:0] op_b;
   logic [DATA_WIDTH-1:0] full_res;
   logic [31:0]           word_res;
   logic [DATA_WIDTH-1:0] alu_res;
   logic                  supported;
   logic                  mem_r_en;
   logic                  mem_w_en;
   logic                  unused_funct7;

   // Only funct7[5] selects between operation variants
   assign unused_funct7 = ^{funct7_ex_i[6], funct7_ex_i[4:0]};

   assign opc        = opcode_e'(opcode_ex_i);
   assign cke        = ~valid_mem_o | ready_mem_i;
   assign ready_ex_o = cke;

   // Operand selection: register forms take rs2, everything else the immediate
   always_comb begin
      reg_src = (opc == OPC_OP) || (opc == OPC_OP_32);
      use_sub = reg_src & funct7_ex_i[5];
      op_b    = reg_src ? rs2_data_ex_i : imm_data_ex_i;
   end

   // 64-bit and 32-bit ALU datapaths, selected by funct3
   always_comb begin
      full_res = '0;
      word_res = '0;
      case (funct3_ex_i)
         3'b000: begin
            full_res = use_sub ? rs1_data_ex_i - op_b : rs1_data_ex_i + op_b;
            word_res = use_sub ? rs1_data_ex_i[31:0] - op_b[31:0]
                               : rs1_data_ex_i[31:0] + op_b[31:0];
         end
         3'b001: begin
            full_res = rs1_data_ex_i << op_b[5:0];
            word_res = rs1_data_ex_i[31:0] << op_b[4:0];
         end
         3'b010: full_res = {{(DATA_WIDTH-1){1'b0}},
                             ($signed(rs1_data_ex_i) < $signed(op_b))};
         3'b011: full_res = {{(DATA_WIDTH-1){1'b0}}, (rs1_data_ex_i < op_b)};
         3'b100: full_res = rs1_data_ex_i ^ op_b;
         3'b101: begin
            full_res = funct7_ex_i[5] ? DATA_WIDTH'($signed(rs1_data_ex_i) >>> op_b[5:0])
                                      : rs1_data_ex_i >> op_b[5:0];
            word_res = funct7_ex_i[5] ? 32'($signed(rs1_data_ex_i[31:0]) >>> op_b[4:0])
                                      : rs1_data_ex_i[31:0] >> op_b[4:0];
         end
         3'b110: full_res = rs1_data_ex_i | op_b;
         default: full_res = rs1_data_ex_i & op_b;
      endcase
   end

   // Result and memory-request selection by opcode
   always_comb begin
      alu_res   = '0;
      supported = 1'b1;
      mem_r_en  = 1'b0;
      mem_w_en  = 1'b0;
      case (opc)
         OPC_OP, OPC_OP_IMM:       alu_res = full_res;
         OPC_OP_32, OPC_OP_IMM_32: alu_res = {{(DATA_WIDTH-32){word_res[31]}}, word_res};
         OPC_LOAD: begin
            alu_res  = rs1_data_ex_i + imm_data_ex_i;
            mem_r_en = 1'b1;
         end
         OPC_STORE: begin
            alu_res  = rs1_data_ex_i + imm_data_ex_i;
            mem_w_en = mem_w_en_ex_i;
         end
         default: supported = 1'b0;
      endcase
   end

   // Output slot: valid follows the input whenever the slot may advance;
   // payload loads only on an actual accept and otherwise holds
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_mem_o      <= 1'b0;
         alu_result_mem_o <= '0;
         store_data_mem_o <= '0;
         rd_addr_mem_o    <= '0;
         rd_en_mem_o      <= 1'b0;
         mem_w_en_mem_o   <= 1'b0;
         mem_r_en_mem_o   <= 1'b0;
         funct3_mem_o     <= '0;
      end else if (cke) begin
         valid_mem_o <= valid_ex_i;
         if (valid_ex_i) begin
            alu_result_mem_o <= alu_res;
            store_data_mem_o <= rs2_data_ex_i;
            rd_addr_mem_o    <= rd_addr_ex_i;
            rd_en_mem_o      <= rd_en_ex_i & (rd_addr_ex_i != 5'd0) & supported;
            mem_w_en_mem_o   <= mem_w_en;
            mem_r_en_mem_o   <= mem_r_en;
            funct3_mem_o     <= funct3_ex_i;
         end
      end
   end

endmodule

// File: tb/tb_cprv_ex_stage.sv
// Scoreboard bench for cprv_ex_stage: stimulus pushes hand-computed
// expectations, a monitor pops and compares on every MEM-side transfer.
module tb_cprv_ex_stage;

   typedef struct {
      string       name;
      logic [63:0] alu;
      logic [63:0] sdata;
      logic [4:0]  rd;
      logic        rd_en;
      logic        wen;
      logic        ren;
      logic [2:0]  f3;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        valid_ex_i = 1'b0;
   logic        ready_ex_o;
   logic [63:0] rs1_data_ex_i = '0;
   logic [63:0] rs2_data_ex_i = '0;
   logic [4:0]  rd_addr_ex_i = '0;
   logic        rd_en_ex_i = 1'b0;
   logic [63:0] imm_data_ex_i = '0;
   logic [6:0]  opcode_ex_i = '0;
   logic [2:0]  funct3_ex_i = '0;
   logic [6:0]  funct7_ex_i = '0;
   logic        mem_w_en_ex_i = 1'b0;
   logic        valid_mem_o;
   logic        ready_mem_i = 1'b1;
   logic [63:0] alu_result_mem_o;
   logic [63:0] store_data_mem_o;
   logic [4:0]  rd_addr_mem_o;
   logic        rd_en_mem_o;
   logic        mem_w_en_mem_o;
   logic        mem_r_en_mem_o;
   logic [2:0]  funct3_mem_o;

   int   total = 0;
   int   bad = 0;
   exp_t sb[$];

   cprv_ex_stage #(.DATA_WIDTH(64)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .valid_ex_i       (valid_ex_i),
      .ready_ex_o       (ready_ex_o),
      .rs1_data_ex_i    (rs1_data_ex_i),
      .rs2_data_ex_i    (rs2_data_ex_i),
      .rd_addr_ex_i     (rd_addr_ex_i),
      .rd_en_ex_i       (rd_en_ex_i),
      .imm_data_ex_i    (imm_data_ex_i),
      .opcode_ex_i      (opcode_ex_i),
      .funct3_ex_i      (funct3_ex_i),
      .funct7_ex_i      (funct7_ex_i),
      .mem_w_en_ex_i    (mem_w_en_ex_i),
      .valid_mem_o      (valid_mem_o),
      .ready_mem_i      (ready_mem_i),
      .alu_result_mem_o (alu_result_mem_o),
      .store_data_mem_o (store_data_mem_o),
      .rd_addr_mem_o    (rd_addr_mem_o),
      .rd_en_mem_o      (rd_en_mem_o),
      .mem_w_en_mem_o   (mem_w_en_mem_o),
      .mem_r_en_mem_o   (mem_r_en_mem_o),
      .funct3_mem_o     (funct3_mem_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h expected=%h", name, got, exp);
      end
   endtask

   // Monitor: every transfer into MEM is matched against the oldest expectation
   always @(negedge clk) begin
      if (rst_n && valid_mem_o && ready_mem_i) begin
         total++;
         if (sb.size() == 0) begin
            bad++;
            $display("FAIL unexpected_output: got alu=%h expected=no transaction", alu_result_mem_o);
         end else begin
            exp_t e;
            e = sb.pop_front();
            if (alu_result_mem_o !== e.alu || store_data_mem_o !== e.sdata ||
                rd_addr_mem_o !== e.rd || rd_en_mem_o !== e.rd_en ||
                mem_w_en_mem_o !== e.wen || mem_r_en_mem_o !== e.ren ||
                funct3_mem_o !== e.f3) begin
               bad++;
               $display("FAIL %s: got alu=%h sd=%h rd=%0d rden=%b wen=%b ren=%b f3=%0d expected alu=%h sd=%h rd=%0d rden=%b wen=%b ren=%b f3=%0d",
                        e.name, alu_result_mem_o, store_data_mem_o, rd_addr_mem_o, rd_en_mem_o,
                        mem_w_en_mem_o, mem_r_en_mem_o, funct3_mem_o,
                        e.alu, e.sdata, e.rd, e.rd_en, e.wen, e.ren, e.f3);
            end
         end
      end
   end

   // Present one instruction and hold it until accepted; called right after a posedge
   task automatic send(input string name, input logic [6:0] opc, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [63:0] rs1, input logic [63:0] rs2,
                       input logic [63:0] imm, input logic [4:0] rd, input logic rden,
                       input logic wen, input logic [63:0] e_alu, input logic e_rden,
                       input logic e_wen, input logic e_ren);
      exp_t e;
      logic acc;
      int   n;
      opcode_ex_i   = opc;
      funct3_ex_i   = f3;
      funct7_ex_i   = f7;
      rs1_data_ex_i = rs1;
      rs2_data_ex_i = rs2;
      imm_data_ex_i = imm;
      rd_addr_ex_i  = rd;
      rd_en_ex_i    = rden;
      mem_w_en_ex_i = wen;
      valid_ex_i    = 1'b1;
      e.name = name; e.alu = e_alu; e.sdata = rs2; e.rd = rd;
      e.rd_en = e_rden; e.wen = e_wen; e.ren = e_ren; e.f3 = f3;
      acc = 1'b0;
      n = 0;
      while (!acc && n < 50) begin
         @(negedge clk);
         acc = ready_ex_o;
         if (acc) sb.push_back(e);
         @(posedge clk);
         #1;
         n++;
      end
      if (!acc) chk({name, "_accept_timeout"}, 64'(acc), 64'd1);
   endtask

   task automatic idle();
      valid_ex_i = 1'b0;
   endtask

   initial begin
      // Reset state
      #12;
      chk("rst_valid", 64'(valid_mem_o), 64'd0);
      chk("rst_alu", alu_result_mem_o, 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("ready_after_rst", 64'(ready_ex_o), 64'd1);
      @(posedge clk); #1;

      // Directed ALU / address vectors: opc f3 f7 rs1 rs2 imm rd rden wen | alu rden wen ren
      send("add_wrap", 7'h33, 3'd0, 7'h00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 5'd5, 1, 0, 64'd0, 1, 0, 0);
      send("sub", 7'h33, 3'd0, 7'h20, 64'd0, 64'd1, 64'd0, 5'd6, 1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 0);
      send("addw", 7'h3B, 3'd0, 7'h00, 64'h7FFF_FFFF, 64'd1, 64'd0, 5'd7, 1, 0, 64'hFFFF_FFFF_8000_0000, 1, 0, 0);
      send("sraiw", 7'h1B, 3'd5, 7'h20, 64'h8000_0000, 64'd0, 64'h404, 5'd8, 1, 0, 64'hFFFF_FFFF_F800_0000, 1, 0, 0);
      send("srai63", 7'h13, 3'd5, 7'h21, 64'h8000_0000_0000_0000, 64'd0, 64'h43F, 5'd9, 1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 0);
      send("srl63", 7'h33, 3'd5, 7'h00, 64'h8000_0000_0000_0000, 64'd63, 64'd0, 5'd9, 1, 0, 64'd1, 1, 0, 0);
      send("slt", 7'h33, 3'd2, 7'h00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 5'd10, 1, 0, 64'd1, 1, 0, 0);
      send("sltu", 7'h33, 3'd3, 7'h00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 5'd11, 1, 0, 64'd0, 1, 0, 0);
      send("sllw", 7'h3B, 3'd1, 7'h00, 64'd1, 64'd31, 64'd0, 5'd12, 1, 0, 64'hFFFF_FFFF_8000_0000, 1, 0, 0);
      send("and", 7'h33, 3'd7, 7'h00, 64'hF0F0, 64'hFF00, 64'd0, 5'd13, 1, 0, 64'hF000, 1, 0, 0);
      send("or", 7'h33, 3'd6, 7'h00, 64'hF0F0, 64'hFF00, 64'd0, 5'd14, 1, 0, 64'hFFF0, 1, 0, 0);
      send("addi_no_sub", 7'h13, 3'd0, 7'h60, 64'h1000, 64'd0, 64'hFFFF_FFFF_FFFF_FC00, 5'd15, 1, 0, 64'hC00, 1, 0, 0);
      send("load", 7'h03, 3'd3, 7'h00, 64'h1000, 64'd0, 64'hFFFF_FFFF_FFFF_FFF8, 5'd16, 1, 0, 64'hFF8, 1, 0, 1);
      send("store", 7'h23, 3'd3, 7'h00, 64'h2000, 64'hAB, 64'h10, 5'd0, 0, 1, 64'h2010, 0, 1, 0);
      send("addi_x0", 7'h13, 3'd0, 7'h00, 64'd5, 64'd0, 64'd7, 5'd0, 1, 0, 64'd12, 0, 0, 0);
      send("lui_unsup", 7'h37, 3'd0, 7'h00, 64'd5, 64'd9, 64'd7, 5'd3, 1, 1, 64'd0, 0, 0, 0);
      idle();
      repeat (3) @(posedge clk);
      #1;

      // Backpressure: four back-to-back ADDI with MEM stalled after the first
      ready_mem_i = 1'b0;
      fork
         begin
            send("bp1", 7'h13, 3'd0, 7'h00, 64'd10, 64'd0, 64'd1, 5'd1, 1, 0, 64'd11, 1, 0, 0);
            send("bp2", 7'h13, 3'd0, 7'h00, 64'd10, 64'd0, 64'd2, 5'd2, 1, 0, 64'd12, 1, 0, 0);
            send("bp3", 7'h13, 3'd0, 7'h00, 64'd10, 64'd0, 64'd3, 5'd3, 1, 0, 64'd13, 1, 0, 0);
            send("bp4", 7'h13, 3'd0, 7'h00, 64'd10, 64'd0, 64'd4, 5'd4, 1, 0, 64'd14, 1, 0, 0);
            idle();
         end
         begin
            int n = 0;
            while (!valid_mem_o && n < 20) begin
               @(posedge clk); #1;
               n++;
            end
            chk("bp_first_valid", 64'(valid_mem_o), 64'd1);
            repeat (3) begin
               @(negedge clk);
               chk("bp_ready_low", 64'(ready_ex_o), 64'd0);
               chk("bp_frozen_alu", alu_result_mem_o, 64'd11);
               chk("bp_frozen_rd", 64'(rd_addr_mem_o), 64'd1);
            end
            @(posedge clk); #1;
            ready_mem_i = 1'b1;
            for (int k = 0; k < 4; k++) begin
               @(negedge clk);
               chk("bp_consecutive_valid", 64'(valid_mem_o), 64'd1);
               chk("bp_consecutive_alu", alu_result_mem_o, 64'(11 + k));
            end
         end
      join
      @(negedge clk);
      chk("bp_drained_valid", 64'(valid_mem_o), 64'd0);
      @(posedge clk); #1;

      // Asynchronous reset while the slot holds a stalled result
      ready_mem_i = 1'b0;
      send("xor_held", 7'h33, 3'd4, 7'h00, 64'd6, 64'd3, 64'd0, 5'd20, 1, 0, 64'd5, 1, 0, 0);
      idle();
      @(negedge clk);
      chk("held_valid", 64'(valid_mem_o), 64'd1);
      chk("held_alu", alu_result_mem_o, 64'd5);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_valid", 64'(valid_mem_o), 64'd0);
      chk("async_alu", alu_result_mem_o, 64'd0);
      chk("async_sdata", store_data_mem_o, 64'd0);
      chk("async_rd", 64'(rd_addr_mem_o), 64'd0);
      chk("async_rden", 64'(rd_en_mem_o), 64'd0);
      chk("async_f3", 64'(funct3_mem_o), 64'd0);
      chk("async_ready", 64'(ready_ex_o), 64'd1);
      sb.delete();
      ready_mem_i = 1'b1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("release_ready", 64'(ready_ex_o), 64'd1);
      chk("release_valid", 64'(valid_mem_o), 64'd0);
      @(posedge clk); #1;

      send("post_rst_add", 7'h33, 3'd0, 7'h00, 64'd40, 64'd2, 64'd0, 5'd21, 1, 0, 64'd42, 1, 0, 0);
      idle();
      begin
         int n = 0;
         while (sb.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
         end
      end
      @(negedge clk);
      chk("scoreboard_empty", 64'(sb.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cprv_ex_stage.md
Name: cprv_ex_stage

Overview:
- Execute stage of the cprv64g in-order pipeline: the receiving end of the ID→EX valid/ready interface.
- Accepts decoded operands and control from the ID stage and computes the RV64I integer ALU result or the load/store effective address.
- Registers the result, with control, into a single pipeline slot toward the MEM stage, using the same valid/ready handshake on its output side.

Parameters:
- DATA_WIDTH, 64, operand/result width (RV64 only; other values unsupported).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- valid_ex_i  in  1  ID stage presents a valid instruction.
- ready_ex_o  out  1  EX can accept this cycle.
- rs1_data_ex_i  in  DATA_WIDTH  rs1 operand.
- rs2_data_ex_i  in  DATA_WIDTH  rs2 operand / store data.
- rd_addr_ex_i  in  5  destination register.
- rd_en_ex_i  in  1  destination write request.
- imm_data_ex_i  in  DATA_WIDTH  immediate, already sign-extended by ID.
- opcode_ex_i  in  7  instr[6:0].
- funct3_ex_i  in  3  instr[14:12].
- funct7_ex_i  in  7  instr[31:25].
- mem_w_en_ex_i  in  1  store flag.
- valid_mem_o  out  1  output slot holds a valid result.
- ready_mem_i  in  1  MEM stage accepts.
- alu_result_mem_o  out  DATA_WIDTH  ALU result or effective address.
- store_data_mem_o  out  DATA_WIDTH  registered rs2 data.
- rd_addr_mem_o  out  5  registered rd.
- rd_en_mem_o  out  1  registered write enable.
- mem_w_en_mem_o  out  1  store request.
- mem_r_en_mem_o  out  1  load request.
- funct3_mem_o  out  3  access size/sign for MEM.

Behaviour:
- Reset:
  - Async assert forces every registered output to 0: valid_mem_o=0, all data/control=0.
  - Reset mid-transfer discards the slot.
  - Release is synchronous to clk; ready_ex_o=1 is the first cycle after release.
- Handshake:
  - cke = ~valid_mem_o | ready_mem_i; ready_ex_o = cke (combinational).
  - Accept when valid_ex_i & cke; the slot loads all outputs on that edge.
  - When cke=1, valid_mem_o <= valid_ex_i. When cke=1 and valid_ex_i=0, the slot empties and data regs may hold.
  - When cke=0 (valid_mem_o=1, ready_mem_i=0), every output holds stable.
  - Simultaneous drain and fill in one cycle sustains 1 instr/cycle.
- Latency: exactly 1 cycle from accept to valid_mem_o; no bubbles under continuous valid/ready.
- ALU, combinational on inputs:
  - OP (0110011):
    - f3=000: add, or sub if funct7[5].
    - f3=001: sll, shift amount rs2[5:0].
    - f3=010: slt (signed).
    - f3=011: sltu.
    - f3=100: xor.
    - f3=101: srl, or sra if funct7[5].
    - f3=110: or.
    - f3=111: and.
  - OP_IMM (0010011): same as OP with imm replacing rs2; shift amount imm[5:0]; f3=000 is always add (no sub); srai when funct7[5].
  - OP_32 (0111011):
    - addw/subw, sllw/srlw/sraw on rs1[31:0], shift amount rs2[4:0].
    - The 32-bit result is sign-extended to 64.
    - sraw shifts the sign of rs1[31].
  - OP_IMM_32 (0011011): addiw, slliw, srliw, sraiw; same rules with imm.
  - LOAD (0000011): result = rs1+imm (mod 2^64); mem_r_en=1.
  - STORE (0100011): result = rs1+imm; mem_w_en = mem_w_en_ex_i.
  - Any other opcode: result=0; mem_r_en=0, mem_w_en=0, rd_en=0.
  - Undefined funct3/funct7 combos in OP*: decoded on funct3 and funct7[5] only.
- rd_en_mem_o <= rd_en_ex_i & (rd_addr_ex_i != 0); writes to x0 are suppressed here.
- store_data_mem_o <= rs2_data_ex_i; funct3_mem_o <= funct3_ex_i.
- Arithmetic wraps modulo 2^64 (2^32 for W ops before extension); no overflow detection.

Test Plan:
- Reset: drive rst_n=0 mid-stream with valid_mem_o=1 → all outputs 0 immediately (async); ready_ex_o=1 after release.
- ADD/SUB:
  - OP f3=000 f7=0, rs1=0xFFFF_FFFF_FFFF_FFFF, rs2=1 → alu_result=0 next cycle, valid_mem_o=1.
  - f7=0x20, rs1=0, rs2=1 → 0xFFFF_FFFF_FFFF_FFFF.
- W-ops:
  - ADDW rs1=0x7FFF_FFFF, rs2=1 → 0xFFFF_FFFF_8000_0000.
  - SRAIW rs1=0x8000_0000, imm=4 → 0xFFFF_FFFF_F800_0000.
  - SRAI rs1=0x8000_0000_0000_0000, imm=63 → all ones.
- Compare/address:
  - SLT rs1=-1, rs2=1 → 1; SLTU same operands → 0.
  - LOAD rs1=0x1000, imm=-8 → result 0x0FF8, mem_r_en=1.
  - STORE rs2=0xAB → store_data=0xAB, mem_w_en=1, rd_en=0.
- Backpressure:
  - Stream 4 back-to-back ADDI; hold ready_mem_i=0 for 3 cycles after the 1st → ready_ex_o=0, outputs frozen.
  - Release → remaining 3 delivered in order on consecutive cycles; none dropped or duplicated.
- x0 / unsupported:
  - ADDI rd=0, rd_en_ex_i=1 → rd_en_mem_o=0.
  - Opcode 0x37 (LUI) → result 0, rd_en 0, valid still propagates.
